// File: rtl/rop3_stream.sv
// Streaming ROP3 engine: every result bit indexes the beat's 8-bit truth table
// by {P,S,D}, behind a 2-stage valid/ready pipeline with a wrapping beat counter.

module rop3_lane (
   input  logic [7:0] mode,
   input  logic       p,
   input  logic       s,
   input  logic       d,
   output logic       r
);
   assign r = mode[{p, s, d}];
endmodule

module rop3_stream #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     P,
   input  logic [N-1:0]     S,
   input  logic [N-1:0]     D,
   input  logic [7:0]       Mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     Result,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             busy
);

   typedef struct packed {
      logic [7:0]   mode;
      logic [N-1:0] p;
      logic [N-1:0] s;
      logic [N-1:0] d;
   } beat_t;

   generate
      if (N < 1)     begin : g_bad_n   $error("rop3_stream: N must be >= 1");     end
      if (CNT_W < 1) begin : g_bad_cnt $error("rop3_stream: CNT_W must be >= 1"); end
   endgenerate

   logic             s1_valid_q, s1_valid_d;
   beat_t            s1_q, s1_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_adv, s1_adv, out_hs;
   logic [N-1:0]     lane_res;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         rop3_lane u_lane (
            .mode (s1_q.mode),
            .p    (s1_q.p[gi]),
            .s    (s1_q.s[gi]),
            .d    (s1_q.d[gi]),
            .r    (lane_res[gi])
         );
      end
   endgenerate

   // Ready depends only on pipeline state and out_ready, never on in_valid.
   assign s2_adv = !out_valid_q || out_ready;
   assign s1_adv = !s1_valid_q || s2_adv;
   assign out_hs = out_valid_q && out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.mode = Mode;
            s1_d.p    = P;
            s1_d.s    = S;
            s1_d.d    = D;
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) result_d = lane_res;
      end
      if (out_hs) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign beat_cnt  = cnt_q;
   assign busy      = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_rop3_stream.sv
// Directed + scoreboarded bench for rop3_stream (N=8, CNT_W=4 so the counter wraps).

module tb_rop3_stream;

   localparam int N     = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [N-1:0]     P, S, D;
   logic [7:0]       Mode;
   logic             out_valid, out_ready;
   logic [N-1:0]     Result;
   logic [CNT_W-1:0] beat_cnt;
   logic             busy;

   int n_chk = 0;
   int n_err = 0;
   bit mon_en = 1'b0;
   int exp_cnt = 0;
   logic [N-1:0] exp_q[$];

   rop3_stream #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .S         (S),
      .D         (D),
      .Mode      (Mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .beat_cnt  (beat_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference as a sum of minterms, one mask per truth-table entry.
   function automatic logic [N-1:0] ref_rop(input logic [N-1:0] p, s, d, input logic [7:0] m);
      logic [N-1:0] r;
      r = '0;
      if (m[0]) r |= ~p & ~s & ~d;
      if (m[1]) r |= ~p & ~s &  d;
      if (m[2]) r |= ~p &  s & ~d;
      if (m[3]) r |= ~p &  s &  d;
      if (m[4]) r |=  p & ~s & ~d;
      if (m[5]) r |=  p & ~s &  d;
      if (m[6]) r |=  p &  s & ~d;
      if (m[7]) r |=  p &  s &  d;
      return r;
   endfunction

   // Scoreboard: inputs are stable from posedge+1 through the next posedge, so negedge sees the handshakes.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
         end else begin
            chk("cnt_model", 32'(beat_cnt), 32'(exp_cnt));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
               else chk("sb_data", 32'(Result), 32'(exp_q.pop_front()));
               exp_cnt = (exp_cnt + 1) & 15;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_rop(P, S, D, Mode));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] p, s, d, m);
      int  n;
      logic acc;
      n = 0;
      P = p; S = s; D = d; Mode = m;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 300);
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (busy !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] modes1 [5];
      logic [7:0] exp1   [5];
      logic [7:0] mp [3], ms [3], md [3], mm [3], me [3];
      bit   done;

      modes1 = '{8'hF0, 8'hCC, 8'hAA, 8'h00, 8'hFF};
      exp1   = '{8'h3C, 8'h5A, 8'h81, 8'h00, 8'hFF};
      mp = '{8'hFF, 8'hF0, 8'h00};
      ms = '{8'h0F, 8'h00, 8'hF0};
      md = '{8'h33, 8'hAA, 8'h3C};
      mm = '{8'h96, 8'h5A, 8'h88};
      me = '{8'hC3, 8'h5A, 8'h30};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      P = '0; S = '0; D = '0; Mode = '0;
      tick();
      rst = 1'b0;
      mon_en = 1'b1;

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result",    32'(Result),    32'd0);
      chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // 1: identity modes back to back
      out_ready = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         if (i < 5) begin
            P = 8'h3C; S = 8'h5A; D = 8'h81; Mode = modes1[i]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         tick();
         if (i >= 1) begin
            chk("t1_valid",  32'(out_valid), 32'd1);
            chk("t1_result", 32'(Result),    32'(exp1[i-1]));
         end
      end
      tick();
      chk("t1_cnt",   32'(beat_cnt),  32'd5);
      chk("t1_empty", 32'(out_valid), 32'd0);

      // 2: mixed modes, then random traffic
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(mp[i], ms[i], md[i], mm[i]);
         tick();
         chk("t2_valid",  32'(out_valid), 32'd1);
         chk("t2_result", 32'(Result),    32'(me[i]));
      end
      drain();

      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
               if ($urandom_range(0, 3) == 0) tick();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      drain();
      chk("t2_cnt", 32'(beat_cnt), 32'(exp_cnt));

      // 3: backpressure holds two beats and keeps Result stable
      do_reset();
      out_ready = 1'b0;
      P = 8'h11; S = 8'h22; D = 8'h33; Mode = 8'hF0; in_valid = 1'b1;
      tick();
      chk("t3_ready_a", 32'(in_ready), 32'd1);
      Mode = 8'hCC;
      tick();
      chk("t3_ready_full", 32'(in_ready),  32'd0);
      chk("t3_valid",      32'(out_valid), 32'd1);
      chk("t3_result_a",   32'(Result),    32'h11);
      Mode = 8'hAA;
      tick();
      tick();
      chk("t3_hold_a",    32'(Result),   32'h11);
      chk("t3_hold_rdy",  32'(in_ready), 32'd0);
      chk("t3_hold_cnt",  32'(beat_cnt), 32'd0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t3_result_b", 32'(Result), 32'h22);
      tick();
      chk("t3_result_c", 32'(Result), 32'h33);
      tick();
      chk("t3_done_valid", 32'(out_valid), 32'd0);
      chk("t3_cnt",        32'(beat_cnt),  32'd3);

      // 4: bubbles on input, random stalls on output
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               send(8'(i * 17), 8'(i * 29 + 3), 8'(i * 7 + 1), 8'(i * 23 + 5));
               tick();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = $urandom_range(0, 1);
               tick();
            end
         end
      join
      drain();

      // 5: counter wrap at 4 bits
      do_reset();
      out_ready = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         P = 8'(c); S = 8'hA5; D = 8'h5A; Mode = 8'hF0;
         in_valid = (c <= 17);
         tick();
         if (c >= 2) chk("t5_cnt", 32'(beat_cnt), 32'((c - 2) & 15));
      end
      in_valid = 1'b0;
      drain();

      // 6: reset with beats in flight
      out_ready = 1'b0;
      send(8'h01, 8'h02, 8'h03, 8'hF0);
      send(8'h04, 8'h05, 8'h06, 8'hF0);
      P = 8'h77; Mode = 8'hF0; in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("t6_valid",    32'(out_valid), 32'd0);
      chk("t6_result",   32'(Result),    32'd0);
      chk("t6_cnt",      32'(beat_cnt),  32'd0);
      chk("t6_busy",     32'(busy),      32'd0);
      chk("t6_in_ready", 32'(in_ready),  32'd1);
      P = 8'h6B; S = 8'h00; D = 8'hFF; Mode = 8'hF0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t6_lat1_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t6_lat2_valid",  32'(out_valid), 32'd1);
      chk("t6_lat2_result", 32'(Result),    32'h6B);
      drain();
      chk("t6_final_cnt", 32'(beat_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rop3_stream.md
Name: rop3_stream

Overview:
- Streaming, pipelined ROP3 raster-operation engine for the blitter datapath.
- Computes an N-bit Result from pattern P, source S and destination D under an 8-bit ROP3 code carried with each beat.
- Replaces the per-mode case decode with truth-table indexing, so all 256 modes come from one generic bit-select per lane.
- Adds a valid/ready handshake with full backpressure, a 2-stage elastic pipeline and a wrap-around beat counter.

Parameters:
N, 8, bit width of P, S, D and Result; must be >= 1
CNT_W, 16, width of the completed-beat counter; must be >= 1

Ports:
clk        input   1      clock; all state updates on rising edge
rst        input   1      synchronous reset, active-high
in_valid   input   1      upstream beat valid
in_ready   output  1      engine can accept a beat this cycle
P          input   N      pattern operand
S          input   N      source operand
D          input   N      destination operand
Mode       input   8      ROP3 code for this beat (truth table)
out_valid  output  1      Result holds a valid beat
out_ready  input   1      downstream accepts Result this cycle
Result     output  N      ROP3 result
beat_cnt   output  CNT_W  number of output handshakes since reset, wraps
busy       output  1      any pipeline stage holds a valid beat

Behaviour:
- Only one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Function, per bit i: Result[i] = Mode[{P[i],S[i],D[i]}], index = 4*P + 2*S + D.
  - Checks: 0xF0 gives P, 0xCC gives S, 0xAA gives D, 0x00 gives 0, 0xFF gives all ones.
  - Mode is captured with its own beat; no global mode register. Mode may change on every beat.
- Handshakes:
  - Input handshake when in_valid && in_ready.
  - Output handshake when out_valid && out_ready.
  - P, S, D and Mode are ignored when no input handshake occurs.
- Stage 1 (input register) holds s1_valid, P, S, D and Mode. Stage 2 (output register) holds out_valid and Result.
- Advance rules:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Stage 1 update:
  - On s1_adv: s1_valid <= in_valid, and operands load only when in_valid.
  - Otherwise stage 1 holds.
- Stage 2 update:
  - On s2_adv: out_valid <= s1_valid, and Result <= f(stage 1) when s1_valid.
  - Otherwise Result and out_valid hold.
  - Result must stay stable while out_valid && !out_ready.
- Latency: a beat accepted at edge k appears on Result/out_valid after edge k+1, i.e. 2 register stages, same as the unhandshaked block.
- Throughput: 1 beat per cycle while out_ready is high.
- Capacity: 2 beats. With out_ready held low, two beats are accepted, then in_ready goes low.
- No beat is ever dropped or duplicated. Order is preserved.
- beat_cnt:
  - Increments by 1 on each output handshake, modulo 2^CNT_W.
  - 2^CNT_W - 1 wraps to 0 with no flag.
- busy = s1_valid || out_valid.
- Reset values (after a clock edge with rst=1):
  - s1_valid=0, out_valid=0, Result=0, beat_cnt=0, busy=0, in_ready=1.
  - Stage 1 operand registers are cleared to 0.
- Reset mid-operation: all in-flight beats are discarded. A beat presented during the reset cycle is not accepted. Normal operation resumes on the first edge with rst=0.
- Simultaneous accept and emit: when stage 1 is full and out_ready=1, stage 1 moves to stage 2 and a new input loads into stage 1 in the same edge.

Test Plan:
1. Identity modes, N=8, out_ready=1: P=0x3C,S=0x5A,D=0x81 with Mode=0xF0, then 0xCC, then 0xAA, then 0x00, then 0xFF on consecutive cycles -> Result 0x3C, 0x5A, 0x81, 0x00, 0xFF. Each appears 2 edges after acceptance, back to back, and beat_cnt ends at 5.
2. Mixed modes: Mode=0x96 with P=0xFF,S=0x0F,D=0x33 -> 0xC3. Mode=0x5A with P=0xF0,D=0xAA -> 0x5A. Mode=0x88 with S=0xF0,D=0x3C -> 0x30. Random 1000 beats over all 256 modes, compared against the bitwise reference model -> zero mismatches.
3. Backpressure: out_ready=0, in_valid=1 with beats A,B,C -> A and B accepted, in_ready=0 after the second acceptance, out_valid=1 with Result=f(A) stable. Raise out_ready -> A, B, C emerge in order, no loss or duplication, beat_cnt=3.
4. Bubbles: in_valid toggles 1,0,1 and out_ready toggles randomly -> output sequence equals input sequence, and busy=0 once drained.
5. Counter wrap, CNT_W=4: 17 output handshakes -> beat_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
6. Reset mid-stream: two beats in flight with out_ready=0, then assert rst for 1 cycle -> out_valid=0, Result=0, beat_cnt=0, busy=0, in_ready=1. The next accepted beat emerges with 2-edge latency.
